// File: rtl/hvac_pkg.sv
// Shared types for the HVAC zone controller: zone state, mode encoding and
// the per-zone control bundle driven by the arbitration logic in the top.
package hvac_pkg;

    typedef enum logic [1:0] {
        ZONE_IDLE = 2'b00,
        ZONE_HEAT = 2'b01,
        ZONE_COOL = 2'b10
    } zone_state_e;

    localparam logic [1:0] MODE_OFF       = 2'b00;
    localparam logic [1:0] MODE_AUTO      = 2'b01;
    localparam logic [1:0] MODE_HEAT_ONLY = 2'b10;
    localparam logic [1:0] MODE_COOL_ONLY = 2'b11;

    typedef struct packed {
        logic heat_en;        // zone may enter HEAT this cycle
        logic cool_en;        // zone may enter COOL this cycle
        logic force_heat_off; // drop HEAT now, dwell ignored
        logic force_cool_off; // drop COOL now, dwell ignored
    } zone_ctl_t;

    function automatic logic heat_mode(input logic [1:0] m);
        return (m == MODE_AUTO) || (m == MODE_HEAT_ONLY);
    endfunction

    function automatic logic cool_mode(input logic [1:0] m);
        return (m == MODE_AUTO) || (m == MODE_COOL_ONLY);
    endfunction

endpackage

// File: rtl/hvac_zone_fsm.sv
// One zone: IDLE/HEAT/COOL state, dwell counter and threshold compares.
// Entry into HEAT/COOL is gated by the enables supplied by the top.
module hvac_zone_fsm
    import hvac_pkg::*;
#(
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  zone_ctl_t         ctl,
    output zone_state_e       state,
    output logic              heat_req
);

    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [DW-1:0]     DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [TEMP_W-1:0] T_HON     = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] T_HOFF    = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] T_CON     = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] T_COFF    = TEMP_W'(COOL_OFF);

    zone_state_e   state_nxt;
    logic [DW-1:0] dwell;
    logic          dwell_ok;
    logic          cool_req;

    assign dwell_ok = (dwell == DWELL_MAX);
    assign heat_req = (state == ZONE_IDLE) && (temp <= T_HON) && dwell_ok;
    assign cool_req = (state == ZONE_IDLE) && (temp >= T_CON) && dwell_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ZONE_IDLE;
            dwell <= '0;
        end else begin
            state <= state_nxt;
            // Any state change, forced or normal, restarts the dwell window.
            if (state_nxt != state)
                dwell <= '0;
            else if (!dwell_ok)
                dwell <= dwell + DW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ZONE_IDLE: begin
                if (heat_req && ctl.heat_en)
                    state_nxt = ZONE_HEAT;
                else if (cool_req && ctl.cool_en)
                    state_nxt = ZONE_COOL;
            end
            ZONE_HEAT: begin
                if (ctl.force_heat_off || (dwell_ok && temp >= T_HOFF))
                    state_nxt = ZONE_IDLE;
            end
            ZONE_COOL: begin
                if (ctl.force_cool_off || (dwell_ok && temp <= T_COFF))
                    state_nxt = ZONE_IDLE;
            end
            default: state_nxt = ZONE_IDLE;
        endcase
    end

endmodule

// File: rtl/hvac_zone_ctrl.sv
// Multi-zone HVAC controller: per-zone FSMs plus shared heat/cool permission
// so the plant never heats and cools at once; heat wins a simultaneous start.
module hvac_zone_ctrl
    import hvac_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic [N_ZONES*TEMP_W-1:0] temp,
    output logic [N_ZONES-1:0]        heating,
    output logic [N_ZONES-1:0]        cooling,
    output logic                      plant_heat,
    output logic                      plant_cool
);

    localparam logic [TEMP_W-1:0] T_HON  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] T_HOFF = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] T_CON  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] T_COFF = TEMP_W'(COOL_OFF);

    if (N_ZONES < 1 || N_ZONES > 16) begin : g_bad_zones
        $fatal(1, "hvac_zone_ctrl: N_ZONES must be 1..16");
    end
    if (!(T_HON < T_HOFF && T_HOFF <= T_COFF && T_COFF < T_CON)) begin : g_bad_thr
        $fatal(1, "hvac_zone_ctrl: thresholds must satisfy HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON");
    end

    zone_state_e        zst [N_ZONES];
    logic [N_ZONES-1:0] heat_req;
    zone_ctl_t          ctl;
    logic               heat_perm;
    logic               cool_perm;

    // Permissions use registered states only, so no zone's entry depends on
    // another zone's entry except for the heat-over-cool tie break below.
    always_comb begin
        heat_perm          = heat_mode(mode) && !(|cooling);
        cool_perm          = cool_mode(mode) && !(|heating);
        ctl                = '0;
        ctl.heat_en        = heat_perm;
        ctl.cool_en        = cool_perm && !(heat_perm && |heat_req);
        ctl.force_heat_off = (mode == MODE_OFF) || (mode == MODE_COOL_ONLY);
        ctl.force_cool_off = (mode == MODE_OFF) || (mode == MODE_HEAT_ONLY);
    end

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        hvac_zone_fsm #(
            .TEMP_W   (TEMP_W),
            .HEAT_ON  (HEAT_ON),
            .HEAT_OFF (HEAT_OFF),
            .COOL_ON  (COOL_ON),
            .COOL_OFF (COOL_OFF),
            .MIN_DWELL(MIN_DWELL)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .temp    (temp[i*TEMP_W +: TEMP_W]),
            .ctl     (ctl),
            .state   (zst[i]),
            .heat_req(heat_req[i])
        );

        assign heating[i] = (zst[i] == ZONE_HEAT);
        assign cooling[i] = (zst[i] == ZONE_COOL);
    end

    assign plant_heat = |heating;
    assign plant_cool = |cooling;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Bench for hvac_zone_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a zone model.
module tb_hvac_zone_ctrl;

    localparam int NZ = 2;
    localparam int TW = 5;
    localparam int MD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       mode;
    logic [NZ*TW-1:0] temp;
    logic [NZ-1:0]    heating;
    logic [NZ-1:0]    cooling;
    logic             plant_heat;
    logic             plant_cool;

    int checks = 0;
    int errors = 0;

    hvac_zone_ctrl #(
        .N_ZONES  (NZ),
        .TEMP_W   (TW),
        .MIN_DWELL(MD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .temp      (temp),
        .heating   (heating),
        .cooling   (cooling),
        .plant_heat(plant_heat),
        .plant_cool(plant_cool)
    );

    always #5 clk = ~clk;

    // Model: zone mode 0=idle 1=heat 2=cool; 'age' counts cycles since the
    // zone last changed mode (unbounded, capped only to avoid overflow).
    int ms  [NZ];
    int age [NZ];
    bit started = 0;

    always @(posedge clk) begin
        int nxt [NZ];
        bit any_h, any_c, h_ok, c_ok;
        int h_entries;
        int t;
        if (!rst_n) begin
            for (int z = 0; z < NZ; z++) begin
                ms[z]  = 0;
                age[z] = 0;
            end
            started = 1;
        end else if (started) begin
            any_h = 0;
            any_c = 0;
            for (int z = 0; z < NZ; z++) begin
                if (ms[z] == 1) any_h = 1;
                if (ms[z] == 2) any_c = 1;
            end
            h_ok = (mode == 2'd1 || mode == 2'd2) && !any_c;
            c_ok = (mode == 2'd1 || mode == 2'd3) && !any_h;
            h_entries = 0;
            for (int z = 0; z < NZ; z++) begin
                t = int'(temp[z*TW +: TW]);
                nxt[z] = ms[z];
                if (ms[z] == 0 && age[z] >= MD && t <= 18 && h_ok) begin
                    nxt[z] = 1;
                    h_entries++;
                end
            end
            for (int z = 0; z < NZ; z++) begin
                t = int'(temp[z*TW +: TW]);
                if (ms[z] == 0 && age[z] >= MD && t >= 22 && c_ok && h_entries == 0)
                    nxt[z] = 2;
                if (ms[z] == 1 && (mode == 2'd0 || mode == 2'd3 || (t >= 20 && age[z] >= MD)))
                    nxt[z] = 0;
                if (ms[z] == 2 && (mode == 2'd0 || mode == 2'd2 || (t <= 20 && age[z] >= MD)))
                    nxt[z] = 0;
            end
            for (int z = 0; z < NZ; z++) begin
                age[z] = (nxt[z] != ms[z]) ? 0 : ((age[z] < 1000) ? age[z] + 1 : age[z]);
                ms[z]  = nxt[z];
            end
        end
    end

    always @(negedge clk) begin
        logic [NZ-1:0] eh, ec;
        if (started) begin
            for (int z = 0; z < NZ; z++) begin
                eh[z] = (ms[z] == 1);
                ec[z] = (ms[z] == 2);
            end
            checks++;
            if ({heating, cooling, plant_heat, plant_cool} !== {eh, ec, |eh, |ec}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got heat=%b cool=%b ph=%b pc=%b want heat=%b cool=%b ph=%b pc=%b",
                         $time, heating, cooling, plant_heat, plant_cool, eh, ec, |eh, |ec);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_t(input int t0, input int t1);
        temp = {TW'(t1), TW'(t0)};
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 2'b01;
        set_t(15, 20);
        repeat (3) step();
        chk("rst_heating", 8'(heating), 8'h0);
        chk("rst_cooling", 8'(cooling), 8'h0);
        chk("rst_plant", 8'({plant_heat, plant_cool}), 8'h0);

        // Dwell after reset release, then heat entry on the fifth edge.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("dwell_after_rst", 8'(heating[0]), 8'h0);
        end
        step();
        chk("heat_entry", 8'(heating[0]), 8'h1);

        // Hot zone stays in HEAT until dwell met, then idles before cooling.
        set_t(25, 20);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("heat_dwell_hold", 8'(heating[0]), 8'h1);
        end
        step();
        chk("heat_exit", 8'(heating[0]), 8'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cool_dwell_wait", 8'(cooling[0]), 8'h0);
        end
        step();
        chk("cool_entry", 8'(cooling[0]), 8'h1);

        // HEAT_ONLY kicks the cooling zone out regardless of dwell.
        mode = 2'b10;
        set_t(30, 20);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("heat_only_force", 8'({heating[0], cooling[0]}), 8'h0);
        end

        // Zone 1 cooling, then mode OFF one cycle into its dwell.
        mode = 2'b01;
        set_t(20, 25);
        step();
        chk("z1_cool_entry", 8'(cooling[1]), 8'h1);
        step();
        chk("z1_cool_hold", 8'(cooling[1]), 8'h1);
        mode = 2'b00;
        step();
        chk("off_force_cool", 8'(cooling[1]), 8'h0);
        chk("off_plant_cool", 8'(plant_cool), 8'h0);

        // Simultaneous heat and cool demand from idle: heat wins.
        set_t(20, 20);
        repeat (6) step();
        mode = 2'b01;
        set_t(15, 25);
        step();
        chk("tie_heat", 8'(heating[0]), 8'h1);
        chk("tie_cool_blocked", 8'(cooling[1]), 8'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("cool_blocked_by_heat", 8'(cooling[1]), 8'h0);
        end
        set_t(21, 25);
        step();
        chk("heat_release", 8'({heating[0], cooling[1]}), 8'h0);
        step();
        chk("cool_after_release", 8'(cooling[1]), 8'h1);

        // Hysteresis sweep on zone 0.
        set_t(21, 20);
        repeat (10) step();
        set_t(18, 20);
        step();
        chk("hyst_on_18", 8'(heating[0]), 8'h1);
        repeat (5) step();
        set_t(19, 20);
        step();
        chk("hyst_hold_19", 8'(heating[0]), 8'h1);
        set_t(20, 20);
        step();
        chk("hyst_off_20", 8'(heating[0]), 8'h0);
        set_t(21, 20);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("deadband_21", 8'({heating, cooling}), 8'h0);
        end

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0)
                mode = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            for (int z = 0; z < NZ; z++)
                if ($urandom_range(0, 3) == 0)
                    temp[z*TW +: TW] = TW'($urandom_range(12, 28));
            step();
        end
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hvac_zone_ctrl.md
HVAC_ZONE_CTRL -- requirements
Module: hvac_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4, number of independent zones (1..16).
REQ-002 Parameter TEMP_W, default 5, unsigned temperature width per zone.
REQ-003 Parameter HEAT_ON, default 18, idle-to-heat threshold (temp <= HEAT_ON).
REQ-004 Parameter HEAT_OFF, default 20, heat-to-idle threshold (temp >= HEAT_OFF).
REQ-005 Parameter COOL_ON, default 22, idle-to-cool threshold (temp >= COOL_ON).
REQ-006 Parameter COOL_OFF, default 20, cool-to-idle threshold (temp <= COOL_OFF).
REQ-007 Parameter MIN_DWELL, default 8, minimum cycles in a state before a normal transition; 0 disables dwell.
REQ-008 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-009 Port rst_n, input, 1; reset is synchronous and active-low.
REQ-010 Port mode, input, 2: 00 OFF, 01 AUTO, 10 HEAT_ONLY, 11 COOL_ONLY.
REQ-011 Port temp, input, N_ZONES*TEMP_W; zone i occupies bits [i*TEMP_W +: TEMP_W].
REQ-012 Port heating, output, N_ZONES; bit i high when zone i is in HEAT.
REQ-013 Port cooling, output, N_ZONES; bit i high when zone i is in COOL.
REQ-014 Port plant_heat / plant_cool, output, 1 each; OR of heating / cooling.

Function
REQ-015 Each zone SHALL run a 3-state FSM: IDLE, HEAT, COOL; no direct HEAT<->COOL transition.
REQ-016 Outputs SHALL decode directly from state registers: temp sampled at edge k is reflected on outputs after edge k (one-cycle latency).
REQ-017 IDLE->HEAT when temp <= HEAT_ON, dwell satisfied, heat permitted; IDLE->COOL when temp >= COOL_ON, dwell satisfied, cool permitted.
REQ-018 HEAT->IDLE when temp >= HEAT_OFF and dwell satisfied; COOL->IDLE when temp <= COOL_OFF and dwell satisfied.
REQ-019 Each zone SHALL hold a dwell counter, width $clog2(MIN_DWELL+1), cleared to 0 on every state change, incrementing each cycle, saturating at MIN_DWELL; dwell is satisfied when counter == MIN_DWELL.
REQ-020 Heat permitted: mode is AUTO or HEAT_ONLY and no zone currently in COOL; cool permitted: mode is AUTO or COOL_ONLY and no zone currently in HEAT (registered states).
REQ-021 If no zone is active and heat and cool entries are requested in the same cycle, all heat entries SHALL be granted and all cool entries blocked.
REQ-022 mode OFF SHALL force every zone to IDLE on the next edge, ignoring dwell; counters cleared for zones that change state.
REQ-023 HEAT_ONLY SHALL force COOL zones to IDLE next edge ignoring dwell; COOL_ONLY likewise forces HEAT zones to IDLE.
REQ-024 Threshold order HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON SHALL be checked at elaboration; violation is a fatal error.
REQ-025 All comparisons SHALL be unsigned at TEMP_W bits; thresholds truncated to TEMP_W.

Reset
REQ-026 rst_n low at a rising edge SHALL set all zones IDLE and all dwell counters to 0; heating, cooling, plant_heat, plant_cool = 0.
REQ-027 Reset asserted mid-operation SHALL override all transitions that cycle; after release no zone may leave IDLE until MIN_DWELL cycles elapse.

Structure
REQ-028 Package hvac_pkg SHALL hold the zone state enum (IDLE, HEAT, COOL) and the mode encoding constants.
REQ-029 One sub-module hvac_zone_fsm (state, dwell counter, threshold compare) SHALL be instantiated N_ZONES times; permission/arbitration logic lives in the top.

Verification (N_ZONES=2, MIN_DWELL=4, defaults otherwise)
REQ-030 Reset, then temp0=15, mode AUTO -> heating[0]=0 for 4 cycles after release, heating[0]=1 after 5th edge.
REQ-031 Zone 0 HEAT for 1 cycle, temp0=25 -> heating[0] held until dwell 4 met, then IDLE; COOL only after 4 further cycles.
REQ-032 Both zones IDLE, dwell met, temp0=15, temp1=25 same cycle -> heating[0]=1, cooling[1]=0; zone 1 cools only after zone 0 returns to IDLE.
REQ-033 Zone 1 COOL with dwell 1, mode -> OFF -> cooling[1]=0 next edge, plant_cool=0.
REQ-034 Hysteresis: zone 0 HEAT, temp0 sweeps 18,19,20 -> heating stays 1 at 19, drops after edge sampling 20; IDLE at 21 produces no output.
REQ-035 Zone 0 COOL, mode -> HEAT_ONLY with temp0=30 -> cooling[0]=0 next edge and stays 0.
